param_step_counter: RTL and testbench
=====================================

Name: param_step_counter

Overview:
- Parametrised modulo-N stepping counter with selectable direction, step size and output encoding (binary or Gray).
- Successor to the fixed 2-bit, single-input sequence FSMs in the sequential-logic exercise set.
- Adds a width/modulus generic, synchronous load, a wrap-around pulse and a terminal-count flag.
- Used as a reusable sequencer/address generator by later exercise blocks.

Parameters:
- WIDTH, 4, bit width of the count, step, load value and output.
- MOD, 16, count modulus; legal range 2..2^WIDTH. The count always lies in 0..MOD-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance the count by one step this cycle
- dir  in  1  0 = count up, 1 = count down
- step  in  WIDTH  step size
- gray  in  1  output encoding: 0 = binary, 1 = Gray
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- q_out  out  WIDTH  registered count in the selected encoding
- wrap  out  1  registered one-cycle pulse when a step crosses the modulus
- tc  out  1  registered terminal count flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst). rst=1 immediately forces cnt=0, q_out=0, wrap=0, tc=0, regardless of the clock. Release takes effect at the next rising edge.
- Internal binary register cnt[WIDTH-1:0] is updated on each rising edge.
- Input clamping:
  - Effective step s = (step >= MOD) ? MOD-1 : step.
  - Effective load L = (load_val >= MOD) ? MOD-1 : load_val.
- Priority per edge is load > en > hold.
  - load=1: cnt_next = L, wrap_next = 0.
  - en=1, dir=0: sum = cnt + s, computed WIDTH+1 bits wide. If sum >= MOD then cnt_next = sum - MOD and wrap_next = 1; otherwise cnt_next = sum and wrap_next = 0.
  - en=1, dir=1: if cnt < s then cnt_next = cnt + MOD - s and wrap_next = 1; otherwise cnt_next = cnt - s and wrap_next = 0.
  - en=1 with s=0: cnt is held and wrap_next = 0.
  - Hold (load=0, en=0): cnt_next = cnt, wrap_next = 0.
- q_out <= gray ? (cnt_next ^ (cnt_next >> 1)) : cnt_next.
  - q_out reflects the new count in the same edge it is updated. There is no extra latency.
  - A change on gray affects q_out from the next edge only, even with en=0. q_out is refreshed every cycle.
- tc <= dir ? (cnt_next == 0) : (cnt_next == MOD-1). tc uses the dir value sampled at the same edge.
- wrap is high for exactly one cycle per wrapping step. Continuous wrapping steps give wrap high on consecutive cycles.
- Simultaneous load and en: load wins, and the step is discarded.
- Reset asserted mid-count: all state is cleared asynchronously. No pending wrap survives reset.
- With MOD = 2^WIDTH and dir=0, s=1, the block is a plain binary/Gray up-counter. In Gray mode, successive values differ in exactly one bit, except at a non-power-of-2 wrap.

Decomposition:
- Shared package (seq_pkg) holds:
  - Direction constants: DIR_UP=1'b0, DIR_DN=1'b1.
  - Encoding constants: ENC_BIN=1'b0, ENC_GRAY=1'b1.
  - Pure function bin2gray(width-generic).
- One combinational sub-module, step_next_calc (WIDTH, MOD), computes cnt_next and wrap_next from cnt, s, dir, en, load and L.
- The top-level module holds only the registers, the encoder and the tc compare.

Test Plan (WIDTH=4, MOD=10 unless stated):
- Reset: rst pulsed mid-cycle while cnt=7 -> q_out, wrap and tc go to 0 immediately, without waiting for a clock edge; the first enabled up step gives q_out=1.
- Up, step=3, binary from 0 -> q_out sequence 3,6,9,2; wrap=1 only on the 9->2 step; tc=1 only while q_out=9.
- Down, step=4, from load 5 -> q_out sequence 1, 7 (wrap=1), 3, 9 (wrap=1); tc never asserts.
- Load priority and clamping:
  - load=1, en=1, load_val=13 -> q_out=9, wrap=0.
  - step=12 with en=1 from 9 -> effective step 9 gives q_out=8, wrap=1.
- Gray mode, MOD=16, step=1 up from 0, 16 cycles -> q_out sequence 0000,0001,0011,0010,0110,... ending at 1000, then wrap=1 on the return to 0000; every transition flips exactly one bit.
- Hold and encoding switch: en=0 with cnt=6 and gray toggled 0->1 -> q_out goes 0110 -> 0101 at the next edge; wrap stays 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and helpers for the stepping-counter family.
// Direction/encoding codes plus width-generic binary-to-Gray and clamp helpers.
package seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DN   = 1'b1;
  localparam logic ENC_BIN  = 1'b0;
  localparam logic ENC_GRAY = 1'b1;

  typedef logic [63:0] word_t;

  // Operates on a 64-bit word; callers zero-extend and truncate back to their width.
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t clamp_below(input word_t v, input word_t lim);
    return (v >= lim) ? lim - word_t'(1) : v;
  endfunction

endpackage

// File: rtl/step_next_calc.sv
// Combinational next-count and wrap computation for the modulo-MOD stepping counter.
// Inputs s and l_val arrive already clamped to 0..MOD-1; priority is load > en > hold.
module step_next_calc
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] s,
  input  logic             dir,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] l_val,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap_next
);

  // Modulus arithmetic is carried one bit wider since the modulus can equal 2^WIDTH.
  localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MOD);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_wrapped;
  logic [WIDTH:0] dn_wrapped;

  assign sum         = {1'b0, cnt} + {1'b0, s};
  assign sum_wrapped = sum - MOD_W;
  assign dn_wrapped  = {1'b0, cnt} + MOD_W - {1'b0, s};

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    cnt_next  = cnt;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = l_val;
    end else if (en && (s != '0)) begin
      if (dir == DIR_UP) begin
        if (sum >= MOD_W) begin
          cnt_next  = sum_wrapped[WIDTH-1:0];
          wrap_next = 1'b1;
        end else begin
          cnt_next = sum[WIDTH-1:0];
        end
      end else begin
        if (cnt < s) begin
          cnt_next  = dn_wrapped[WIDTH-1:0];
          wrap_next = 1'b1;
        end else begin
          cnt_next = cnt - s;
        end
      end
    end
  end

endmodule

// File: rtl/param_step_counter.sv
// Modulo-MOD up/down stepping counter with load, wrap pulse, terminal count and
// selectable binary/Gray output; all outputs are registered from the next count.
module param_step_counter
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic             gray,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);
  localparam word_t            MOD_WORD = word_t'(MOD);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] l_eff;

  assign s_eff = WIDTH'(clamp_below(word_t'(step), MOD_WORD));
  assign l_eff = WIDTH'(clamp_below(word_t'(load_val), MOD_WORD));

  step_next_calc #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .cnt       (cnt_q),
    .s         (s_eff),
    .dir       (dir),
    .en        (en),
    .load      (load),
    .l_val     (l_eff),
    .cnt_next  (cnt_d),
    .wrap_next (wrap_d)
  );

  // Encoding and tc both look at the new count so q_out has no extra latency.
  always_comb begin
    q_d  = (gray == ENC_GRAY) ? WIDTH'(bin2gray(word_t'(cnt_d))) : cnt_d;
    tc_d = (dir == DIR_DN) ? (cnt_d == '0) : (cnt_d == CNT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      q_q    <= '0;
      wrap_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
      tc_q   <= tc_d;
    end
  end

  assign q_out = q_q;
  assign wrap  = wrap_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_param_step_counter.sv
// Self-checking bench: MOD=10 instance driven from a vector table, MOD=16 instance
// exercised in Gray mode; expected outputs flow through a scoreboard queue.
module tb_param_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, dir, gray, load;
  logic [3:0] step, load_val;
  logic [3:0] q10, q16;
  logic       w10, w16, t10, t16;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       dir;
    logic [3:0] step;
    logic       gray;
    logic [3:0] q;
    logic       wrap;
    logic       tc;
  } vec_t;

  typedef struct {
    int         dut;
    logic [5:0] exp;
    string      name;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[21];

  always #5 clk = ~clk;

  param_step_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .gray(gray),
    .load(load), .load_val(load_val), .q_out(q10), .wrap(w10), .tc(t10)
  );

  param_step_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .gray(gray),
    .load(load), .load_val(load_val), .q_out(q16), .wrap(w16), .tc(t16)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [3:0] lv, input logic e,
                       input logic d, input logic [3:0] st, input logic g);
    load = l; load_val = lv; en = e; dir = d; step = st; gray = g;
  endtask

  task automatic expect_out(input int dut, input logic [3:0] q, input logic w,
                            input logic t, input string name);
    sb.push_back('{dut: dut, exp: {q, w, t}, name: name});
  endtask

  // Advance one edge, then compare every pending expectation against its DUT.
  task automatic tick();
    sb_t        e;
    logic [5:0] act;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = (e.dut == 10) ? {q10, w10, t10} : {q16, w16, t16};
      check(e.name, int'(act), int'(e.exp));
    end
  endtask

  initial begin
    logic [3:0] c;
    logic [3:0] g;
    logic [3:0] prev;

    //          load  lv     en    dir   step   gray  q      wrap  tc
    vecs = '{
      '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b0, 4'd3,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b0, 4'd6,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b0, 4'd9,  1'b0, 1'b1},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b0, 4'd2,  1'b1, 1'b0},
      '{1'b1, 4'd5,  1'b0, 1'b1, 4'd4,  1'b0, 4'd5,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  1'b0, 4'd1,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  1'b0, 4'd7,  1'b1, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  1'b0, 4'd3,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  1'b0, 4'd9,  1'b1, 1'b0},
      '{1'b1, 4'd13, 1'b1, 1'b0, 4'd3,  1'b0, 4'd9,  1'b0, 1'b1},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 1'b0, 4'd8,  1'b1, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 1'b0, 4'd7,  1'b1, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 4'd7,  1'b0, 1'b0},
      '{1'b1, 4'd6,  1'b0, 1'b0, 4'd0,  1'b0, 4'd6,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b1, 4'd5,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 4'd6,  1'b0, 1'b0},
      '{1'b1, 4'd1,  1'b0, 1'b1, 4'd1,  1'b0, 4'd1,  1'b0, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 4'd0,  1'b0, 1'b1},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 4'd9,  1'b1, 1'b0},
      '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  1'b1, 4'd12, 1'b0, 1'b0}
    };

    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #2;
    check("reset_state_m10", int'({q10, w10, t10}), 0);
    check("reset_state_m16", int'({q16, w16, t16}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Load 7, then assert reset mid-cycle and look before any clock edge.
    drive(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out(10, 4'd7, 1'b0, 1'b0, "load7");
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_m10", int'({q10, w10, t10}), 0);
    check("async_reset_m16", int'({q16, w16, t16}), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0);
    expect_out(10, 4'd1, 1'b0, 1'b0, "first_step_after_reset_m10");
    expect_out(16, 4'd1, 1'b0, 1'b0, "first_step_after_reset_m16");
    tick();

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].dir,
            vecs[i].step, vecs[i].gray);
      expect_out(10, vecs[i].q, vecs[i].wrap, vecs[i].tc, $sformatf("vec%0d", i));
      tick();
    end

    // Gray up-count on the full-range instance: 16 steps from 0 back to 0.
    drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1);
    expect_out(16, 4'd0, 1'b0, 1'b0, "gray_load0");
    tick();
    prev = q16;
    for (int i = 1; i <= 16; i++) begin
      c = 4'(i);
      g = c ^ (c >> 1);
      drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1);
      expect_out(16, g, (i == 16), (c == 4'd15), $sformatf("gray_step%0d", i));
      tick();
      check($sformatf("gray_onebit%0d", i), $countones(q16 ^ prev), 1);
      prev = q16;
    end

    // Reset while a wrap pulse is pending must clear it.
    drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_clears_wrap_m16", int'({q16, w16, t16}), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
